// File: rtl/imem_loader.sv
// Byte-stream loader: packs 4 LE bytes into a word written to imem at sequential addresses; 1 write cycle per 4 accepted bytes.
// Backpressure: byte_ready drops during the write cycle and outside a load; byte_valid gaps stall indefinitely.
module imem_loader #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] len_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  state_t      state;
  logic [15:0] len_q;
  logic [15:0] idx;
  logic [15:0] idx_inc;
  logic [1:0]  bcnt;
  logic [23:0] asm_q;
  logic        accept;

  assign idx_inc = idx + 16'd1;
  assign accept  = (state == LOAD) && byte_valid && byte_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      idx        <= '0;
      bcnt       <= '0;
      asm_q      <= '0;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len_q <= len_words;
            idx   <= '0;
            bcnt  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            if ({1'b0, len_words} > DEPTH_L) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (len_words == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= LOAD;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            bcnt <= bcnt + 2'd1;
            // the fourth byte goes straight into wdata, so no extra cycle is spent assembling
            if (bcnt == 2'd3) begin
              we         <= 1'b1;
              wdata      <= {byte_data, asm_q};
              waddr      <= {14'b0, idx, 2'b00};
              byte_ready <= 1'b0;
              state      <= WRITE;
            end else begin
              case (bcnt)
                2'd0:    asm_q[7:0]   <= byte_data;
                2'd1:    asm_q[15:8]  <= byte_data;
                default: asm_q[23:16] <= byte_data;
              endcase
            end
          end
        end
        WRITE: begin
          idx <= idx_inc;
          if (idx_inc == len_q) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= LOAD;
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
